// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit product in WIDTH RUN cycles.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands and product (sign-magnitude around the core).
module seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod_shift;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   result;

`ifdef SEQ_MUL_SIGNED_EN
    logic sign_q, sign_d;
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;
    assign result = sign_q ? -prod_shift : prod_shift;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = prod_shift;
`endif

    always_comb begin
        // The WIDTH+1-bit sum holds the carry; shifting it in as the new MSB
        // means the carry position above the product is always zero afterwards.
        sum        = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_shift = {sum, prod_q[WIDTH-1:1]};

        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        p_d     = p_q;
`ifdef SEQ_MUL_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a_mag;
                    prod_d  = {{WIDTH{1'b0}}, b_mag};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef SEQ_MUL_SIGNED_EN
                    sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                prod_d = prod_shift;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    p_d     = result;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
`ifdef SEQ_MUL_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;
endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at WIDTH=8 and WIDTH=2; expected products come from plain
// integer arithmetic, signed when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_mul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        start2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    seq_mul #(.WIDTH(8)) u_mul8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
                                 .busy(busy8), .done(done8), .p(p8));
    seq_mul #(.WIDTH(2)) u_mul2 (.clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
                                 .busy(busy2), .done(done2), .p(p2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp8_q[$];
    int          acc8_q[$];
    logic [3:0]  exp2_q[$];
    int          acc2_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MUL_SIGNED_EN
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        return 16'(sx * sy);
`else
        return 16'(int'(x) * int'(y));
`endif
    endfunction

    function automatic logic [3:0] model2(input logic [1:0] x, input logic [1:0] y);
`ifdef SEQ_MUL_SIGNED_EN
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        return 4'(sx * sy);
`else
        return 4'(int'(x) * int'(y));
`endif
    endfunction

    // Monitors: pop the scoreboard whenever done is presented.
    logic        prev_done8 = 1'b0, prev_done2 = 1'b0;
    logic [15:0] e8;
    logic [3:0]  e2;
    int          ac8, ac2;

    always @(negedge clk) begin
        if (done8) begin
            check("w8_done_single", 32'(prev_done8), 32'd0);
            if (exp8_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL w8_unexpected_done: got done with p=%h, required no done", p8);
            end else begin
                e8  = exp8_q.pop_front();
                ac8 = acc8_q.pop_front();
                check("w8_product", 32'(p8), 32'(e8));
                check("w8_latency", 32'(cyc - ac8), 32'd8);
                $display("w8 txn: p=%h expected=%h edges_after_accept=%0d", p8, e8, cyc - ac8);
            end
        end
        prev_done8 <= done8;
    end

    always @(negedge clk) begin
        if (done2) begin
            check("w2_done_single", 32'(prev_done2), 32'd0);
            if (exp2_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL w2_unexpected_done: got done with p=%h, required no done", p2);
            end else begin
                e2  = exp2_q.pop_front();
                ac2 = acc2_q.pop_front();
                check("w2_product", 32'(p2), 32'(e2));
                check("w2_latency", 32'(cyc - ac2), 32'd2);
                $display("w2 txn: p=%h expected=%h edges_after_accept=%0d", p2, e2, cyc - ac2);
            end
        end
        prev_done2 <= done2;
    end

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy8) check("w8_idle_timeout", 32'(busy8), 32'd0);
    endtask

    task automatic wait_idle2();
        int n = 0;
        while (busy2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy2) check("w2_idle_timeout", 32'(busy2), 32'd0);
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        wait_idle8();
        start8 = 1'b1;
        a8     = x;
        b8     = y;
        @(posedge clk);
        #1;
        exp8_q.push_back(e);
        acc8_q.push_back(cyc);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic issue2(input logic [1:0] x, input logic [1:0] y, input logic [3:0] e);
        wait_idle2();
        start2 = 1'b1;
        a2     = x;
        b2     = y;
        @(posedge clk);
        #1;
        exp2_q.push_back(e);
        acc2_q.push_back(cyc);
        start2 = 1'b0;
        a2     = 2'($urandom);
        b2     = 2'($urandom);
        @(negedge clk);
    endtask

    task automatic busy_window8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        int hi = 0;
        issue8(x, y, e);
        for (int k = 0; k < 12; k++) begin
            if (busy8) hi++;
            @(negedge clk);
        end
        check("w8_busy_cycles", 32'(hi), 32'd9);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int acc, dn, n;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_p8", 32'(p8), 32'd0);
        check("reset_busy2", 32'(busy2), 32'd0);
        check("reset_p2", 32'(p2), 32'd0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SEQ_MUL_SIGNED_EN
        busy_window8(8'hFD, 8'd5, 16'hFFF1);
        issue8(8'h80, 8'h80, 16'h4000);
        issue8(8'h80, 8'h01, 16'hFF80);
        issue8(8'h07, 8'hFF, 16'hFFF9);
`else
        busy_window8(8'd255, 8'd255, 16'hFE01);
        issue8(8'd1, 8'd200, 16'd200);
`endif
        issue8(8'd0, 8'd173, 16'd0);

        // start held high across DONE: second accept lands WIDTH+2 edges after the first
        wait_idle8();
        start8 = 1'b1;
        a8 = 8'd13;
        b8 = 8'd7;
        @(posedge clk);
        #1;
        acc = cyc;
        exp8_q.push_back(model8(8'd13, 8'd7));
        acc8_q.push_back(acc);
        a8 = 8'd6;
        b8 = 8'd9;
        exp8_q.push_back(model8(8'd6, 8'd9));
        acc8_q.push_back(acc + 10);
        repeat (10) @(posedge clk);
        #1;
        start8 = 1'b0;
        check("w8_b2b_second_accept", 32'(busy8), 32'd1);
        @(negedge clk);

        // start pulse during RUN must not disturb the running product
        issue8(8'd91, 8'd47, model8(8'd91, 8'd47));
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8 = 8'd3;
        b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;

        // reset in the 4th RUN cycle aborts the operation
        issue8(8'd200, 8'd100, model8(8'd200, 8'd100));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp8_q.delete();
        acc8_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("w8_abort_busy", 32'(busy8), 32'd0);
        check("w8_abort_p", 32'(p8), 32'd0);
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        check("w8_abort_no_done", 32'(dn), 32'd0);

        // reset wins over start in the same cycle
        rst = 1'b1;
        start8 = 1'b1;
        a8 = 8'd5;
        b8 = 8'd5;
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b0;
        check("w8_rst_over_start", 32'(busy8), 32'd0);

        issue8(8'd12, 8'd11, 16'd132);

        for (int t = 0; t < 40; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue8(ra, rb, model8(ra, rb));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 16; i++) begin
            logic [3:0] ij;
            ij = 4'(i);
            issue2(ij[3:2], ij[1:0], model2(ij[3:2], ij[1:0]));
        end

        n = 0;
        while ((exp8_q.size() != 0 || exp2_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp8_q.size() != 0 || exp2_q.size() != 0)
            check("drain_timeout", 32'(exp8_q.size() + exp2_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-add multiplier: the multi-cycle, width-generic successor to the team's 2-bit combinational array multiplier. It accepts two WIDTH-bit operands on a start strobe and computes the full 2*WIDTH-bit product over WIDTH clock cycles using one WIDTH-bit adder. It signals completion with a one-cycle done pulse. It sits in the datapath where area matters more than latency, and replaces wide combinational multipliers.

## Interface
- WIDTH, default 8: operand width in bits. Legal range is 2 to 32.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on the accepted start.
- b  input  WIDTH  multiplier; captured on the accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; p is valid in this cycle.
- p  output  2*WIDTH  product; holds the last result until the next accepted start.

## Operation
- Three states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - If start=1, capture a into the multiplicand register mcand and b into the low half of the product register.
  - Clear the upper half and the extra carry bit to 0 and clear the bit counter to 0.
  - Go to RUN.
  - If start=0, stay in IDLE.
- RUN, per cycle:
  - If product[0]=1, add mcand to the upper WIDTH bits. The sum is WIDTH+1 bits, and the carry goes into the extra bit.
  - Shift the {carry, upper, lower} register right by one.
  - Increment the counter.
  - When the counter reaches WIDTH-1 in a RUN cycle, the next state is DONE.
- DONE:
  - done=1 and p = final register value.
  - Go to IDLE unconditionally.
  - start is ignored in this cycle.
- start while busy=1 is ignored. It is not queued, and a and b are not sampled.
- a and b may change freely after the accepting edge; only the captured copies are used.
- p is driven from the result register. It changes only at the end of the final RUN cycle and on reset.
- Arithmetic:
  - Unsigned.
  - The product is exact; no overflow is possible in 2*WIDTH bits.
  - The accumulator carries WIDTH+1 bits internally so that no carry is lost.

## Timing
- Reset (rst=1 at an edge) forces IDLE, busy=0, done=0, p=0, counter=0 and all internal registers to 0. This takes effect in the following cycle.
- Reset mid-operation (in RUN or DONE) aborts the computation:
  - No done pulse is produced.
  - p reads 0.
  - rst wins over start in the same cycle.
- Latency and throughput:
  - If start is accepted at edge E0, busy is high from E0 to E(WIDTH+1).
  - done is high for exactly the cycle after E(WIDTH), giving a latency of WIDTH+1 cycles.
  - Throughput is one product per WIDTH+2 cycles. The minimum gap is a start held continuously high, which is accepted again in the IDLE cycle after DONE.
- done never stays high for two consecutive cycles.

## Configuration
- SEQ_MUL_SIGNED_EN, when defined:
  - a, b and p are two's complement.
  - In IDLE, magnitudes are captured and the sign XOR is stored.
  - On the transition RUN->DONE, the result is negated if the sign XOR is 1.
  - Latency is unchanged.
  - The most negative operand (-2^(WIDTH-1)) is handled exactly, because the magnitude register is WIDTH bits unsigned.
- When not defined: purely unsigned, with no sign logic compiled in.

## Test plan
- WIDTH=8, unsigned:
  - Reset, then start with a=255, b=255 -> done exactly 9 cycles after the accepting edge, p=16'hFE01.
  - busy high 9 cycles.
- WIDTH=8: a=0, b=173 -> p=0.
- WIDTH=8: a=1, b=200 -> p=200.
- WIDTH=8: back-to-back start held high -> second accept in the cycle after done.
- WIDTH=8: start pulsed during RUN with different operands -> ignored; first result unchanged.
- WIDTH=8: assert rst in the 4th RUN cycle -> next cycle busy=0, p=0, no done; a subsequent start of 12*11 gives p=132.
- WIDTH=2: exhaustive 16 operand pairs -> p=a*b for each, including 3*3=9; done 3 cycles after each accept.
- SEQ_MUL_SIGNED_EN, WIDTH=8:
  - -3*5 -> p=16'hFFF1.
  - -128*-128 -> p=16'h4000.
  - -128*1 -> p=16'hFF80.
  - 7*-1 -> p=16'hFFF9.
